// File: rtl/meduram_pkg.sv
// Shared definitions for the banked multi-port scratch RAM.
//   ARB_FIXED / ARB_RR : arbitration mode encodings
//   COLL_WR / COLL_RD  : bit positions inside each read port's 2-bit collision field
//   bank_of()          : bank index of a word address (low address bits)
package meduram_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam int COLL_WR = 0;
    localparam int COLL_RD = 1;

    // nb_bank is a power of two, so the bank is simply the low address bits.
    function automatic int bank_of(input int addr, input int nb_bank);
        return addr & (nb_bank - 1);
    endfunction

endpackage

// File: rtl/meduram_arbiter.sv
// Per-bank N-way arbiter.
//   aclk, aresetn : clock, asynchronous active-low reset
//   req_i[N]      : requests targeting this bank
//   mode_i        : 0 = fixed priority (lowest index wins), 1 = round-robin
//   grant_o[N]    : one-hot grant (all zero when nothing is requested)
// The round-robin pointer only moves on contested grants, to winner + 1.
module meduram_arbiter #(
    parameter int N = 2
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic [N-1:0] req_i,
    input  logic         mode_i,
    output logic [N-1:0] grant_o
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    logic          contested;
    int            win;
    int            cand;

    // More than one request bit set.
    assign contested = (req_i & (req_i - N'(1))) != '0;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        win     = 0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = mode_i ? (int'(ptr_q) + i) % N : i;
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                win           = cand;
                found         = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (mode_i && found && contested) begin
            ptr_d = PW'((win + 1) % N);
        end
    end

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/meduram_banked_mp.sv
// Multi-port banked scratch RAM with valid/ready handshakes.
//   aclk, aresetn          : clock, asynchronous active-low reset
//   wrvalid/wrready        : per write port handshake (ready is combinational)
//   wraddr/wrdata          : packed write address/data, port 0 in LSBs
//   rdvalid/rdready        : per read port handshake (ready is combinational)
//   rdaddr                 : packed read addresses
//   rddvalid/rddata        : read response, one cycle after acceptance
//   rdcollision            : per read port {read collision, write-collision tag}
// Each bank writes and reads at most one address per cycle; every port aimed at
// the winning address of its bank is accepted together, other ports stall.
module meduram_banked_mp
    import meduram_pkg::*;
#(
    parameter int ADDR_WIDTH      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int NB_WR           = 2,
    parameter int NB_RD           = 2,
    parameter int NB_BANK         = 4,
    parameter int ARB_MODE        = 0,
    parameter int WRITE_COLLISION = 1,
    parameter int READ_COLLISION  = 1
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [NB_WR-1:0]            wrvalid,
    output logic [NB_WR-1:0]            wrready,
    input  logic [NB_WR*ADDR_WIDTH-1:0] wraddr,
    input  logic [NB_WR*DATA_WIDTH-1:0] wrdata,
    input  logic [NB_RD-1:0]            rdvalid,
    output logic [NB_RD-1:0]            rdready,
    input  logic [NB_RD*ADDR_WIDTH-1:0] rdaddr,
    output logic [NB_RD-1:0]            rddvalid,
    output logic [NB_RD*DATA_WIDTH-1:0] rddata,
    output logic [NB_RD*2-1:0]          rdcollision
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Unpacked views of the packed port buses.
    logic [ADDR_WIDTH-1:0] wa [NB_WR];
    logic [DATA_WIDTH-1:0] wd [NB_WR];
    logic [ADDR_WIDTH-1:0] ra [NB_RD];

    // Per-bank request / grant vectors and resolved bank operations.
    logic [NB_WR-1:0]      wr_req   [NB_BANK];
    logic [NB_WR-1:0]      wr_gnt   [NB_BANK];
    logic [NB_RD-1:0]      rd_req   [NB_BANK];
    logic [NB_RD-1:0]      rd_gnt   [NB_BANK];
    logic                  wr_en    [NB_BANK];
    logic [ADDR_WIDTH-1:0] wr_baddr [NB_BANK];
    logic [DATA_WIDTH-1:0] wr_bdata [NB_BANK];
    logic                  wr_multi [NB_BANK];
    logic                  wr_seen  [NB_BANK];
    logic                  rd_en    [NB_BANK];
    logic [ADDR_WIDTH-1:0] rd_baddr [NB_BANK];
    logic                  rd_cont  [NB_BANK];

    logic [NB_WR-1:0] wr_acc;
    logic [NB_RD-1:0] rd_acc;
    logic [NB_RD-1:0] rd_coll_rd;

    logic [DATA_WIDTH-1:0]       mem_q [DEPTH];
    logic [DEPTH-1:0]            tag_q;
    logic [NB_RD-1:0]            rddvalid_q;
    logic [NB_RD*DATA_WIDTH-1:0] rddata_q;
    logic [NB_RD*2-1:0]          rdcoll_q;

    always_comb begin
        for (int p = 0; p < NB_WR; p++) begin
            wa[p] = wraddr[p*ADDR_WIDTH +: ADDR_WIDTH];
            wd[p] = wrdata[p*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int p = 0; p < NB_RD; p++) begin
            ra[p] = rdaddr[p*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    always_comb begin
        for (int b = 0; b < NB_BANK; b++) begin
            for (int p = 0; p < NB_WR; p++) begin
                wr_req[b][p] = wrvalid[p] && (bank_of(int'(wa[p]), NB_BANK) == b);
            end
            for (int p = 0; p < NB_RD; p++) begin
                rd_req[b][p] = rdvalid[p] && (bank_of(int'(ra[p]), NB_BANK) == b);
            end
        end
    end

    for (genvar b = 0; b < NB_BANK; b++) begin : g_bank
        meduram_arbiter #(.N(NB_WR)) u_wr_arb (
            .aclk    (aclk),
            .aresetn (aresetn),
            .req_i   (wr_req[b]),
            .mode_i  (ARB_MODE == ARB_RR),
            .grant_o (wr_gnt[b])
        );
        meduram_arbiter #(.N(NB_RD)) u_rd_arb (
            .aclk    (aclk),
            .aresetn (aresetn),
            .req_i   (rd_req[b]),
            .mode_i  (ARB_MODE == ARB_RR),
            .grant_o (rd_gnt[b])
        );
    end

    // Write resolution: the winner fixes the bank address; every writer to that
    // address is accepted. Scanning downwards leaves the lowest-index data.
    always_comb begin
        wr_acc = '0;
        for (int b = 0; b < NB_BANK; b++) begin
            wr_en[b]    = 1'b0;
            wr_baddr[b] = '0;
            wr_bdata[b] = '0;
            wr_multi[b] = 1'b0;
            wr_seen[b]  = 1'b0;
            for (int p = 0; p < NB_WR; p++) begin
                if (wr_gnt[b][p]) begin
                    wr_en[b]    = 1'b1;
                    wr_baddr[b] = wa[p];
                end
            end
            for (int p = NB_WR - 1; p >= 0; p--) begin
                if (wr_req[b][p] && wr_en[b] && (wa[p] == wr_baddr[b])) begin
                    wr_acc[p]   = 1'b1;
                    wr_bdata[b] = wd[p];
                    if (wr_seen[b]) wr_multi[b] = 1'b1;
                    wr_seen[b]  = 1'b1;
                end
            end
        end
    end

    // Read resolution: broadcast to every reader of the winning address.
    // A read collision is any other reader in the same bank this cycle.
    always_comb begin
        rd_acc     = '0;
        rd_coll_rd = '0;
        for (int b = 0; b < NB_BANK; b++) begin
            rd_en[b]    = 1'b0;
            rd_baddr[b] = '0;
            rd_cont[b]  = (rd_req[b] & (rd_req[b] - NB_RD'(1))) != '0;
            for (int p = 0; p < NB_RD; p++) begin
                if (rd_gnt[b][p]) begin
                    rd_en[b]    = 1'b1;
                    rd_baddr[b] = ra[p];
                end
            end
            for (int p = 0; p < NB_RD; p++) begin
                if (rd_req[b][p]) begin
                    rd_coll_rd[p] = rd_cont[b];
                    if (rd_en[b] && (ra[p] == rd_baddr[b])) rd_acc[p] = 1'b1;
                end
            end
        end
    end

    // A single port never competes, so it is always ready.
    assign wrready = (NB_WR == 1) ? {NB_WR{1'b1}} : wr_acc;
    assign rdready = (NB_RD == 1) ? {NB_RD{1'b1}} : rd_acc;

    // NOTE: the storage array has no reset; contents are undefined until written.
    always_ff @(posedge aclk) begin
        for (int b = 0; b < NB_BANK; b++) begin
            if (wr_en[b]) mem_q[wr_baddr[b]] <= wr_bdata[b];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tag_q <= '0;
        end else begin
            for (int b = 0; b < NB_BANK; b++) begin
                if (wr_en[b]) tag_q[wr_baddr[b]] <= wr_multi[b];
            end
        end
    end

    // Reads sample the pre-write array and tag, giving read-first behaviour.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rddvalid_q <= '0;
            rddata_q   <= '0;
            rdcoll_q   <= '0;
        end else begin
            for (int p = 0; p < NB_RD; p++) begin
                rddvalid_q[p] <= rd_acc[p];
                if (rd_acc[p]) begin
                    rddata_q[p*DATA_WIDTH +: DATA_WIDTH] <= mem_q[ra[p]];
                    rdcoll_q[p*2 + COLL_WR] <= (WRITE_COLLISION != 0) && tag_q[ra[p]];
                    rdcoll_q[p*2 + COLL_RD] <= (READ_COLLISION != 0) && rd_coll_rd[p];
                end
            end
        end
    end

    assign rddvalid    = rddvalid_q;
    assign rddata      = rddata_q;
    assign rdcollision = rdcoll_q;

endmodule

// File: tb/tb_meduram_banked_mp.sv
// Scoreboard bench for meduram_banked_mp: a fixed-priority instance (dut0)
// carries the data/collision scenarios, a round-robin instance (dut1) the
// fairness and reset scenarios.
module tb_meduram_banked_mp;

    typedef struct {
        logic [7:0] data;
        logic [1:0] coll;
    } exp_t;

    logic aclk = 1'b0;
    logic aresetn;

    logic [1:0]  w0_valid, w0_ready, r0_valid, r0_ready, r0_dvalid;
    logic [7:0]  w0_addr, r0_addr;
    logic [15:0] w0_data, r0_data;
    logic [3:0]  r0_coll;

    logic [1:0]  w1_valid, w1_ready, r1_valid, r1_ready, r1_dvalid;
    logic [7:0]  w1_addr, r1_addr;
    logic [15:0] w1_data, r1_data;
    logic [3:0]  r1_coll;

    int   n_vec  = 0;
    int   n_fail = 0;
    exp_t exp_q [2][$];

    always #5 aclk = ~aclk;

    meduram_banked_mp #(.ARB_MODE(0)) dut0 (
        .aclk(aclk), .aresetn(aresetn),
        .wrvalid(w0_valid), .wrready(w0_ready), .wraddr(w0_addr), .wrdata(w0_data),
        .rdvalid(r0_valid), .rdready(r0_ready), .rdaddr(r0_addr),
        .rddvalid(r0_dvalid), .rddata(r0_data), .rdcollision(r0_coll)
    );

    meduram_banked_mp #(.ARB_MODE(1)) dut1 (
        .aclk(aclk), .aresetn(aresetn),
        .wrvalid(w1_valid), .wrready(w1_ready), .wraddr(w1_addr), .wrdata(w1_data),
        .rdvalid(r1_valid), .rdready(r1_ready), .rdaddr(r1_addr),
        .rddvalid(r1_dvalid), .rddata(r1_data), .rdcollision(r1_coll)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_wr(input logic [1:0] v, input logic [3:0] a0, input logic [7:0] d0,
                            input logic [3:0] a1, input logic [7:0] d1);
        w0_valid = v;
        w0_addr  = {a1, a0};
        w0_data  = {d1, d0};
    endtask

    task automatic drive_rd(input logic [1:0] v, input logic [3:0] a0, input logic [3:0] a1);
        r0_valid = v;
        r0_addr  = {a1, a0};
    endtask

    task automatic idle();
        w0_valid = '0;
        r0_valid = '0;
    endtask

    // Checks readies for the cycle, queues expected read responses, advances one clock.
    task automatic cycle_chk(input logic [1:0] exp_wr, input logic [1:0] exp_rd,
                             input logic [7:0] e0, input logic [1:0] c0,
                             input logic [7:0] e1, input logic [1:0] c1);
        exp_t e;
        @(negedge aclk);
        check("wrready", 32'(w0_ready), 32'(exp_wr));
        check("rdready", 32'(r0_ready), 32'(exp_rd));
        if (exp_rd[0]) begin e.data = e0; e.coll = c0; exp_q[0].push_back(e); end
        if (exp_rd[1]) begin e.data = e1; e.coll = c1; exp_q[1].push_back(e); end
        @(posedge aclk);
        #1;
    endtask

    // Monitor: every read response of dut0 is matched against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn) begin
            for (int p = 0; p < 2; p++) begin
                if (r0_dvalid[p]) begin
                    if (exp_q[p].size() == 0) begin
                        check("unexpected rddvalid", 32'(p + 1), 32'(0));
                    end else begin
                        exp_t e;
                        e = exp_q[p].pop_front();
                        check("rddata", 32'(r0_data[p*8 +: 8]), 32'(e.data));
                        check("rdcollision", 32'(r0_coll[p*2 +: 2]), 32'(e.coll));
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        aresetn  = 1'b0;
        w0_valid = '0; w0_addr = '0; w0_data = '0; r0_valid = '0; r0_addr = '0;
        w1_valid = '0; w1_addr = '0; w1_data = '0; r1_valid = '0; r1_addr = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("reset rddvalid", 32'(r0_dvalid), 32'(0));
        check("reset rddata", 32'(r0_data), 32'(0));
        check("reset rdcollision", 32'(r0_coll), 32'(0));
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Basic write then read on another port.
        drive_wr(2'b01, 4'd5, 8'hA3, 4'd0, 8'h00);
        cycle_chk(2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b10, 4'd0, 4'd5);
        cycle_chk(2'b00, 2'b10, 8'h00, 2'd0, 8'hA3, 2'd0);
        idle();

        // Same-address write collision: lowest port's data kept, tag set.
        drive_wr(2'b11, 4'd6, 8'h11, 4'd6, 8'h22);
        cycle_chk(2'b11, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b01, 4'd6, 4'd0);
        cycle_chk(2'b00, 2'b01, 8'h11, 2'd1, 8'h00, 2'd0);
        idle();
        drive_wr(2'b01, 4'd6, 8'h33, 4'd0, 8'h00);
        cycle_chk(2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b01, 4'd6, 4'd0);
        cycle_chk(2'b00, 2'b01, 8'h33, 2'd0, 8'h00, 2'd0);
        idle();

        // Read-during-write: old data and old tag come back, new ones next time.
        drive_wr(2'b11, 4'd6, 8'h44, 4'd6, 8'h55);
        drive_rd(2'b01, 4'd6, 4'd0);
        cycle_chk(2'b11, 2'b01, 8'h33, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b01, 4'd6, 4'd0);
        cycle_chk(2'b00, 2'b01, 8'h44, 2'd1, 8'h00, 2'd0);
        idle();

        // Broadcast read of one address to both ports.
        drive_wr(2'b10, 4'd0, 8'h00, 4'd3, 8'h5C);
        cycle_chk(2'b10, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b11, 4'd3, 4'd3);
        cycle_chk(2'b00, 2'b11, 8'h5C, 2'd2, 8'h5C, 2'd2);
        idle();

        // Writers to one bank at different addresses: port 1 stalls one cycle.
        drive_wr(2'b11, 4'd2, 8'h12, 4'd10, 8'h9A);
        cycle_chk(2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        drive_wr(2'b10, 4'd2, 8'h12, 4'd10, 8'h9A);
        cycle_chk(2'b10, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b11, 4'd10, 4'd5);
        cycle_chk(2'b00, 2'b11, 8'h9A, 2'd0, 8'hA3, 2'd0);
        idle();

        // Same-bank reads at different addresses, fixed priority.
        drive_wr(2'b01, 4'd1, 8'h77, 4'd0, 8'h00);
        cycle_chk(2'b01, 2'b00, 8'h00, 2'd0, 8'h00, 2'd0);
        idle();
        drive_rd(2'b11, 4'd1, 4'd5);
        cycle_chk(2'b00, 2'b01, 8'h77, 2'd2, 8'h00, 2'd0);
        drive_rd(2'b10, 4'd1, 4'd5);
        cycle_chk(2'b00, 2'b10, 8'h00, 2'd0, 8'hA3, 2'd0);
        idle();

        repeat (3) @(posedge aclk);
        #1;
        check("scoreboard drained", 32'(exp_q[0].size() + exp_q[1].size()), 32'(0));

        // Round-robin: two writers to bank 0 alternate, starting with port 0.
        w1_valid = 2'b11;
        w1_addr  = {4'd4, 4'd0};
        w1_data  = {8'hBB, 8'hAA};
        for (int k = 0; k < 9; k++) begin
            @(negedge aclk);
            check("rr grant", 32'(w1_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            @(posedge aclk);
            #1;
        end
        w1_valid = '0;

        // Reset during an accepted read: the result is dropped, pointer returns to 0.
        r1_valid = 2'b01;
        r1_addr  = {4'd0, 4'd0};
        @(negedge aclk);
        check("rr rdready before reset", 32'(r1_ready), 32'h1);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        r1_valid = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        check("rddvalid after reset", 32'(r1_dvalid), 32'(0));
        @(posedge aclk);
        #1;
        check("rddvalid after release", 32'(r1_dvalid), 32'(0));
        w1_valid = 2'b11;
        @(negedge aclk);
        check("rr grant after reset", 32'(w1_ready), 32'h1);
        @(posedge aclk);
        #1;
        w1_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
